branch_predict_ctrl: RTL
========================

# branch_predict_ctrl

Dynamic branch-prediction controller for the five-stage CPU. Holds a 2-bit saturating branch history table (BHT) read at fetch, and drives the `op_compare` select of the compare unit for the branch in EX. It checks the returned `CP_result` against the prediction carried down the pipe and updates the BHT. On a mispredict it sequences a pipeline flush and a PC redirect.

## Interface
Parameters:
- `IDX_W`, 4 — BHT index width; 2^IDX_W entries, indexed by `pc[IDX_W+1:2]`.
- `INIT_CTR`, 2'b01 — reset value of every BHT entry (weakly not-taken).
- `FLUSH_CYCLES`, 2 — cycles `flush` stays high per mispredict; legal range 1..3.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `if_pc`  in  32  — fetch PC for lookup.
- `pred_taken`  out  1  — prediction for `if_pc`; equals BHT[idx][1].
- `ex_valid`  in  1  — EX stage holds a live instruction.
- `ex_is_branch`  in  1  — EX instruction is a conditional branch.
- `ex_br_type`  in  2  — branch type: 0 eq, 1 ne, 2 lt, 3 le.
- `ex_pc`  in  32  — PC of the EX branch.
- `ex_pred_taken`  in  1  — prediction carried from fetch.
- `ex_target`  in  32  — taken target.
- `op_compare`  out  2  — to the compare unit; equals `ex_br_type` (combinational).
- `cp_result`  in  1  — branch condition from the compare unit, same cycle.
- `flush`  out  1  — squash IF/ID/EX.
- `redirect_valid`  out  1  — load `redirect_pc` into the PC.
- `redirect_pc`  out  32  — corrected fetch address.
- `br_count`  out  16  — resolved-branch counter.
- `miss_count`  out  16  — mispredict counter.

## Operation
- Resolve condition: `res = ex_valid & ex_is_branch & (state==IDLE)`.
- Actual outcome: `taken = cp_result`.
- Mispredict: `res & (taken != ex_pred_taken)`.
- BHT update on `res`: entry at `ex_pc[IDX_W+1:2]` saturates.
  - Taken: increment, capped at 3.
  - Not taken: decrement, floored at 0.
- Counters:
  - `br_count` increments on every `res`.
  - `miss_count` increments on every mispredict.
  - Both saturate at 16'hFFFF; they do not wrap.
- Redirect target: `ex_target` if taken, else `ex_pc + 4` (32-bit modular add).
- FSM has states IDLE and FLUSH.
  - IDLE → FLUSH on mispredict. Load `redirect_pc`, load `fcnt = FLUSH_CYCLES-1`.
  - FLUSH: `flush=1`. `redirect_valid=1` only in the first FLUSH cycle. Decrement `fcnt`.
  - FLUSH → IDLE when `fcnt==0`.
- Squashing in FLUSH: `ex_valid`/`ex_is_branch` are ignored. No BHT update, no count, no new redirect.
- Same-index read/write in one cycle: `pred_taken` returns the pre-update value (read-before-write).
- Non-branch or invalid EX: no state change. `op_compare` still follows `ex_br_type`.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - Every BHT entry becomes `INIT_CTR`.
  - State IDLE, `flush=0`, `redirect_valid=0`, `redirect_pc=0`.
  - `br_count=0`, `miss_count=0`.
- Reset asserted mid-FLUSH aborts the flush in the next cycle.
- `pred_taken` and `op_compare` are combinational, 0-cycle latency.
- Resolution in cycle N:
  - BHT and counters update at the end of cycle N.
  - `flush` and `redirect_valid` are registered and first high in cycle N+1.
  - `flush` is high for cycles N+1 .. N+FLUSH_CYCLES.
  - `redirect_pc` is stable from N+1 until the next mispredict.
- Earliest next resolution: cycle N+FLUSH_CYCLES+1.
- Correct prediction produces no flush and no bubble.

## Structure
- Package `bp_pkg`:
  - Branch-type constants `BR_EQ`, `BR_NE`, `BR_LT`, `BR_LE`.
  - Counter constants `SNT=0`, `WNT=1`, `WT=2`, `ST=3`.
  - FSM state enum `{IDLE, FLUSH}`.
- Sub-module `sat_ctr2`: combinational 2-bit saturating next-value (inputs `ctr`, `taken`). Instantiated once on the update path.
- BHT implemented as a flop array, not RAM, so that reset can initialise it.

## Test plan
- Reset then lookup: `rst_n=0` for 2 cycles, `if_pc=0x40` → `pred_taken=0`, counters 0, `flush=0`.
- Training: 2 consecutive resolutions at `ex_pc=0x40`, `cp_result=1`, `ex_pred_taken` = current prediction.
  - After both, `if_pc=0x40` gives `pred_taken=1`.
  - `miss_count` increments only on the first resolution.
- Mispredict taken: `ex_pc=0x100`, `ex_target=0x200`, pred 0, `cp_result=1` in cycle N.
  - `flush=1` for N+1..N+2; `redirect_valid=1` only in N+1; `redirect_pc=0x200`.
  - A branch presented in N+1 is ignored (`br_count` unchanged).
- Mispredict not-taken: `ex_pc=0xFFFFFFFC`, pred 1, `cp_result=0` → `redirect_pc=0x00000000` (wrap).
- Saturation and same-cycle read: 5 taken updates at one index leave the entry at 3; the lookup in the update cycle shows the old value.
  - With `miss_count` preloaded to 0xFFFF by forced stimulus, a further mispredict leaves it at 0xFFFF.
- Reset mid-flush: assert `rst_n=0` in the first FLUSH cycle → next cycle `flush=0`, state IDLE, BHT back to `INIT_CTR`.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the branch-prediction controller:
// compare-unit branch types, 2-bit counter encodings and the FSM state.
package bp_pkg;

    localparam logic [1:0] BR_EQ = 2'd0;
    localparam logic [1:0] BR_NE = 2'd1;
    localparam logic [1:0] BR_LT = 2'd2;
    localparam logic [1:0] BR_LE = 2'd3;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

endpackage

// File: rtl/sat_ctr2.sv
// Combinational next value of a 2-bit saturating predictor counter:
// moves toward ST when taken, toward SNT when not taken, never wraps.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor: 2-bit BHT looked up at fetch, trained by the
// EX-stage branch outcome, with a flush/redirect sequencer on mispredict.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int         IDX_W        = 4,
    parameter logic [1:0] INIT_CTR     = 2'b01,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [1:0]  ex_br_type,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    output logic [1:0]  op_compare,
    input  logic        cp_result,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_count,
    output logic [15:0] miss_count
);

    localparam int         ENTRIES   = 1 << IDX_W;
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_nxt;
    logic             res;
    logic             mispredict;
    bp_state_t        state, state_nxt;
    logic [1:0]       fcnt, fcnt_nxt;

    // Only the word-index bits of the fetch PC address the table.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign if_idx     = if_pc[IDX_W+1:2];
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign pred_taken = bht[if_idx][1];
    assign op_compare = ex_br_type;

    assign res        = ex_valid & ex_is_branch & (state == IDLE);
    assign mispredict = res & (cp_result != ex_pred_taken);
    assign flush      = (state == FLUSH);

    sat_ctr2 u_sat_ctr2 (
        .ctr   (bht[ex_idx]),
        .taken (cp_result),
        .nxt   (ctr_nxt)
    );

    // NOTE: the BHT is a flop array rather than a RAM so reset can load every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= INIT_CTR;
            end
        end else if (res) begin
            bht[ex_idx] <= ctr_nxt;
        end
    end

    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FCNT_INIT;
                end
            end
            FLUSH: begin
                if (fcnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    fcnt_nxt = fcnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops sample together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            fcnt           <= 2'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            state          <= state_nxt;
            fcnt           <= fcnt_nxt;
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= cp_result ? ex_target : ex_pc + 32'd4;
            end
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count   <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (res && br_count != 16'hFFFF) begin
                br_count <= br_count + 16'd1;
            end
            if (mispredict && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule
